// File: rtl/execute_stage.sv
// ---------------------------------------------------------------------------
// execute_stage
// Execute (X) stage of the 16-bit five-stage pipeline. It takes decoded
// operands and control from the D/X register and resolves forwarding from
// the M and W stages. It then performs the ALU operation and registers the
// 41-bit X/M bundle for the memory stage. It also holds the architectural
// {Z, V, N} flag register that branch resolution reads.
//
// Ports
//   clk, rst              clock; synchronous active-high reset
//   stall_i               hold X/M register and flags
//   flush_i               load a bubble (all zero) into X/M
//   opcode_i              instruction opcode
//   rs1_id_i, rs2_id_i    source register numbers (used for forwarding)
//   rs1_data_i, rs2_data_i register-file read data
//   imm_i                 sign-extended immediate
//   pc_plus2_i            PC+2 of this instruction (PCS result)
//   wr_reg_i              destination register
//   MemRead_i .. Halt_i   control bits from decode
//   M_wr_reg_i, M_RegWrite_i, M_result_i   forwarding source in M
//   W_wr_reg_i, W_RegWrite_i, W_data_i     forwarding source in W
//   XM_out_o              {alu[15:0], store[15:0], wr_reg[3:0],
//                          MemWrite, MemtoReg, RegWrite, Halt, MemRead}
//   flags_o               registered {Z, V, N}
// ---------------------------------------------------------------------------
module execute_stage (
    input  logic        clk,
    input  logic        rst,
    input  logic        stall_i,
    input  logic        flush_i,
    input  logic [3:0]  opcode_i,
    input  logic [3:0]  rs1_id_i,
    input  logic [3:0]  rs2_id_i,
    input  logic [15:0] rs1_data_i,
    input  logic [15:0] rs2_data_i,
    input  logic [15:0] imm_i,
    input  logic [15:0] pc_plus2_i,
    input  logic [3:0]  wr_reg_i,
    input  logic        MemRead_i,
    input  logic        MemWrite_i,
    input  logic        RegWrite_i,
    input  logic        MemtoReg_i,
    input  logic        Halt_i,
    input  logic [3:0]  M_wr_reg_i,
    input  logic        M_RegWrite_i,
    input  logic [15:0] M_result_i,
    input  logic [3:0]  W_wr_reg_i,
    input  logic        W_RegWrite_i,
    input  logic [15:0] W_data_i,
    output logic [40:0] XM_out_o,
    output logic [2:0]  flags_o
);

    typedef enum logic [3:0] {
        OP_ADD    = 4'b0000,
        OP_SUB    = 4'b0001,
        OP_XOR    = 4'b0010,
        OP_RED    = 4'b0011,
        OP_SLL    = 4'b0100,
        OP_SRA    = 4'b0101,
        OP_ROR    = 4'b0110,
        OP_PADDSB = 4'b0111,
        OP_LW     = 4'b1000,
        OP_SW     = 4'b1001,
        OP_LLB    = 4'b1010,
        OP_LHB    = 4'b1011,
        OP_B      = 4'b1100,
        OP_BR     = 4'b1101,
        OP_PCS    = 4'b1110,
        OP_HLT    = 4'b1111
    } opcode_e;

    opcode_e     op;
    logic [15:0] opA;
    logic [15:0] opB;
    logic [3:0]  shAmt;

    logic [15:0] addSum;
    logic        addOvf;
    logic [15:0] addSat;
    logic [15:0] subDiff;
    logic        subOvf;
    logic [15:0] subSat;
    logic [15:0] redRes;
    logic [15:0] sllRes;
    logic [15:0] sraRes;
    logic [31:0] rorWide;
    logic [15:0] rorRes;
    logic [15:0] paddsbRes;
    logic [15:0] aluRes;
    logic [2:0]  flagsNew;

    logic [40:0] xmOut_q;
    logic [40:0] xmOut_d;
    logic [2:0]  flags_q;
    logic [2:0]  flags_d;

    assign op    = opcode_e'(opcode_i);
    assign shAmt = imm_i[3:0];

    // Operand forwarding: M wins over W, and R0 is never forwarded because
    // it reads as a constant in the register file.
    always_comb begin
        opA = rs1_data_i;
        if (M_RegWrite_i && (M_wr_reg_i == rs1_id_i) && (rs1_id_i != 4'd0)) begin
            opA = M_result_i;
        end else if (W_RegWrite_i && (W_wr_reg_i == rs1_id_i) && (rs1_id_i != 4'd0)) begin
            opA = W_data_i;
        end
    end

    always_comb begin
        opB = rs2_data_i;
        if (M_RegWrite_i && (M_wr_reg_i == rs2_id_i) && (rs2_id_i != 4'd0)) begin
            opB = M_result_i;
        end else if (W_RegWrite_i && (W_wr_reg_i == rs2_id_i) && (rs2_id_i != 4'd0)) begin
            opB = W_data_i;
        end
    end

    // Saturating add/sub: overflow is detected from operand and result signs,
    // and the clamp direction follows the sign of A.
    always_comb begin
        addSum  = opA + opB;
        addOvf  = (opA[15] == opB[15]) && (addSum[15] != opA[15]);
        addSat  = addOvf ? (opA[15] ? 16'h8000 : 16'h7FFF) : addSum;
        subDiff = opA - opB;
        subOvf  = (opA[15] != opB[15]) && (subDiff[15] != opA[15]);
        subSat  = subOvf ? (opA[15] ? 16'h8000 : 16'h7FFF) : subDiff;
    end

    // Reduction sum of the four signed bytes. The worst case (-512..508)
    // fits comfortably in 16 bits, so no saturation is needed.
    always_comb begin
        redRes = {{8{opA[15]}}, opA[15:8]} + {{8{opB[15]}}, opB[15:8]}
               + {{8{opA[7]}},  opA[7:0]}  + {{8{opB[7]}},  opB[7:0]};
    end

    // Shifts and rotate. The rotate shifts a doubled copy so that amount 0
    // passes A through without a special case.
    always_comb begin
        sllRes  = opA << shAmt;
        sraRes  = $unsigned($signed(opA) >>> shAmt);
        rorWide = {opA, opA} >> shAmt;
        rorRes  = rorWide[15:0];
    end

    // PADDSB: each nibble is a separate signed lane. It is widened by one
    // bit so that the two top bits differ exactly when the lane overflows.
    always_comb begin
        logic [4:0] laneSum;
        paddsbRes = 16'h0000;
        laneSum   = 5'b00000;
        for (int i = 0; i < 4; i++) begin
            laneSum = {opA[4*i+3], opA[4*i +: 4]} + {opB[4*i+3], opB[4*i +: 4]};
            if (laneSum[4] != laneSum[3]) begin
                paddsbRes[4*i +: 4] = laneSum[4] ? 4'h8 : 4'h7;
            end else begin
                paddsbRes[4*i +: 4] = laneSum[3:0];
            end
        end
    end

    // Result select and the candidate flag value for this instruction.
    // XOR and shifts refresh only Z; other non-arithmetic ops leave flags alone.
    always_comb begin
        aluRes   = 16'h0000;
        flagsNew = flags_q;
        case (op)
            OP_ADD: begin
                aluRes   = addSat;
                flagsNew = {(addSat == 16'h0000), addOvf, addSat[15]};
            end
            OP_SUB: begin
                aluRes   = subSat;
                flagsNew = {(subSat == 16'h0000), subOvf, subSat[15]};
            end
            OP_XOR: begin
                aluRes   = opA ^ opB;
                flagsNew = {((opA ^ opB) == 16'h0000), flags_q[1:0]};
            end
            OP_RED:    aluRes = redRes;
            OP_SLL: begin
                aluRes   = sllRes;
                flagsNew = {(sllRes == 16'h0000), flags_q[1:0]};
            end
            OP_SRA: begin
                aluRes   = sraRes;
                flagsNew = {(sraRes == 16'h0000), flags_q[1:0]};
            end
            OP_ROR: begin
                aluRes   = rorRes;
                flagsNew = {(rorRes == 16'h0000), flags_q[1:0]};
            end
            OP_PADDSB: aluRes = paddsbRes;
            OP_LW,
            OP_SW:     aluRes = (opA & 16'hFFFE) + imm_i;
            OP_LLB:    aluRes = (opA & 16'hFF00) | {8'h00, imm_i[7:0]};
            OP_LHB:    aluRes = (opA & 16'h00FF) | {imm_i[7:0], 8'h00};
            OP_PCS:    aluRes = pc_plus2_i;
            default:   aluRes = 16'h0000;
        endcase
    end

    // X/M register next state. Flush beats stall, so flush+stall still
    // loads a bubble, while flags move only on a real load.
    always_comb begin
        xmOut_d = xmOut_q;
        flags_d = flags_q;
        if (flush_i) begin
            xmOut_d = 41'h0;
        end else if (!stall_i) begin
            xmOut_d = {aluRes, opB, wr_reg_i, MemWrite_i, MemtoReg_i,
                       RegWrite_i, Halt_i, MemRead_i};
            flags_d = flagsNew;
        end
    end

    // State registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            xmOut_q <= 41'h0;
            flags_q <= 3'b000;
        end else begin
            xmOut_q <= xmOut_d;
            flags_q <= flags_d;
        end
    end

    assign XM_out_o = xmOut_q;
    assign flags_o  = flags_q;

endmodule

// File: tb/tb_execute_stage.sv
// ---------------------------------------------------------------------------
// tb_execute_stage
// Table-driven self-checking bench for execute_stage, followed by
// hand-written flush, stall and reset sequences.
// ---------------------------------------------------------------------------
module tb_execute_stage;

    logic        clk;
    logic        rst;
    logic        stall;
    logic        flush;
    logic [3:0]  opcode;
    logic [3:0]  rs1Id;
    logic [3:0]  rs2Id;
    logic [15:0] rs1Data;
    logic [15:0] rs2Data;
    logic [15:0] imm;
    logic [15:0] pcPlus2;
    logic [3:0]  wrReg;
    logic        memRead;
    logic        memWrite;
    logic        regWrite;
    logic        memtoReg;
    logic        halt;
    logic [3:0]  mWrReg;
    logic        mRegWrite;
    logic [15:0] mResult;
    logic [3:0]  wWrReg;
    logic        wRegWrite;
    logic [15:0] wData;
    logic [40:0] xmOut;
    logic [2:0]  flags;

    int errors = 0;
    int checks = 0;

    // ctrl = {MemWrite, MemtoReg, RegWrite, Halt, MemRead}
    localparam logic [4:0] CR  = 5'b00100;
    localparam logic [4:0] CSW = 5'b10000;
    localparam logic [4:0] CLW = 5'b01101;
    localparam logic [4:0] CH  = 5'b00010;
    localparam logic [4:0] CN  = 5'b00000;

    typedef struct {
        logic [3:0]  op;
        logic [3:0]  rs1Id;
        logic [3:0]  rs2Id;
        logic [15:0] a;
        logic [15:0] b;
        logic [15:0] imm;
        logic [15:0] pc;
        logic [3:0]  wr;
        logic [4:0]  ctrl;
        logic [3:0]  mWr;
        logic        mRW;
        logic [15:0] mRes;
        logic [3:0]  wWr;
        logic        wRW;
        logic [15:0] wDat;
        logic [15:0] expAlu;
        logic [15:0] expStore;
        logic [2:0]  expFlags;
    } vec_t;

    vec_t vecs[27];

    execute_stage dut (
        .clk          (clk),
        .rst          (rst),
        .stall_i      (stall),
        .flush_i      (flush),
        .opcode_i     (opcode),
        .rs1_id_i     (rs1Id),
        .rs2_id_i     (rs2Id),
        .rs1_data_i   (rs1Data),
        .rs2_data_i   (rs2Data),
        .imm_i        (imm),
        .pc_plus2_i   (pcPlus2),
        .wr_reg_i     (wrReg),
        .MemRead_i    (memRead),
        .MemWrite_i   (memWrite),
        .RegWrite_i   (regWrite),
        .MemtoReg_i   (memtoReg),
        .Halt_i       (halt),
        .M_wr_reg_i   (mWrReg),
        .M_RegWrite_i (mRegWrite),
        .M_result_i   (mResult),
        .W_wr_reg_i   (wWrReg),
        .W_RegWrite_i (wRegWrite),
        .W_data_i     (wData),
        .XM_out_o     (xmOut),
        .flags_o      (flags)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Drive one instruction's worth of inputs.
    task automatic applyStimulus(input vec_t v);
        opcode    = v.op;
        rs1Id     = v.rs1Id;
        rs2Id     = v.rs2Id;
        rs1Data   = v.a;
        rs2Data   = v.b;
        imm       = v.imm;
        pcPlus2   = v.pc;
        wrReg     = v.wr;
        memWrite  = v.ctrl[4];
        memtoReg  = v.ctrl[3];
        regWrite  = v.ctrl[2];
        halt      = v.ctrl[1];
        memRead   = v.ctrl[0];
        mWrReg    = v.mWr;
        mRegWrite = v.mRW;
        mResult   = v.mRes;
        wWrReg    = v.wWr;
        wRegWrite = v.wRW;
        wData     = v.wDat;
    endtask

    // Compare the full X/M bundle and the flag register.
    task automatic checkOutput(input string name, input logic [40:0] expXm,
                               input logic [2:0] expFl);
        checks++;
        if (xmOut !== expXm) begin
            errors++;
            $display("[TB] FAIL %s xm: got alu=%h st=%h low=%h want alu=%h st=%h low=%h",
                     name, xmOut[40:25], xmOut[24:9], xmOut[8:0],
                     expXm[40:25], expXm[24:9], expXm[8:0]);
        end
        checks++;
        if (flags !== expFl) begin
            errors++;
            $display("[TB] FAIL %s flags: got %b want %b", name, flags, expFl);
        end
    endtask

    function automatic logic [40:0] pack(input logic [15:0] alu, input logic [15:0] st,
                                         input logic [3:0] wr, input logic [4:0] ctrl);
        return {alu, st, wr, ctrl};
    endfunction

    initial begin
        vec_t v;

        //          op     r1 r2  a        b        imm      pc       wr ctrl mWr mRW mRes     wWr wRW wDat     expAlu   expSt    flg
        vecs[0]  = '{4'h0, 1, 2, 16'h0003, 16'h0004, 16'h0000, 16'h0000, 1, CR, 0, 0, 16'h0000, 0, 0, 16'h0000, 16'h0007, 16'h0004, 3'b000};
        vecs[1]  = '{4'h0, 1, 2, 16'h7FFF, 16'h0001, 16'h0000, 16'h0000, 1, CR, 0, 0, 16'h0000, 0, 0, 16'h0000, 16'h7FFF, 16'h0001, 3'b010};
        vecs[2]  = '{4'h1, 1, 2, 16'h8000, 16'h0001, 16'h0000, 16'h0000, 1, CR, 0, 0, 16'h0000, 0, 0, 16'h0000, 16'h8000, 16'h0001, 3'b011};
        vecs[3]  = '{4'h2, 1, 2, 16'h1234, 16'h1234, 16'h0000, 16'h0000, 1, CR, 0, 0, 16'h0000, 0, 0, 16'h0000, 16'h0000, 16'h1234, 3'b111};
        vecs[4]  = '{4'h0, 1, 2, 16'h0001, 16'hFFFF, 16'h0000, 16'h0000, 1, CR, 0, 0, 16'h0000, 0, 0, 16'h0000, 16'h0000, 16'hFFFF, 3'b100};
        vecs[5]  = '{4'h2, 1, 2, 16'h00F0, 16'h000F, 16'h0000, 16'h0000, 1, CR, 0, 0, 16'h0000, 0, 0, 16'h0000, 16'h00FF, 16'h000F, 3'b000};
        vecs[6]  = '{4'h1, 1, 2, 16'h0000, 16'h0001, 16'h0000, 16'h0000, 1, CR, 0, 0, 16'h0000, 0, 0, 16'h0000, 16'hFFFF, 16'h0001, 3'b001};
        vecs[7]  = '{4'h4, 1, 2, 16'h8001, 16'h0000, 16'h0004, 16'h0000, 1, CR, 0, 0, 16'h0000, 0, 0, 16'h0000, 16'h0010, 16'h0000, 3'b001};
        vecs[8]  = '{4'h4, 1, 2, 16'h8000, 16'h0000, 16'h0001, 16'h0000, 1, CR, 0, 0, 16'h0000, 0, 0, 16'h0000, 16'h0000, 16'h0000, 3'b101};
        vecs[9]  = '{4'h5, 1, 2, 16'h8000, 16'h0000, 16'h000F, 16'h0000, 1, CR, 0, 0, 16'h0000, 0, 0, 16'h0000, 16'hFFFF, 16'h0000, 3'b001};
        vecs[10] = '{4'h6, 1, 2, 16'h1234, 16'h0000, 16'h0004, 16'h0000, 1, CR, 0, 0, 16'h0000, 0, 0, 16'h0000, 16'h4123, 16'h0000, 3'b001};
        vecs[11] = '{4'h6, 1, 2, 16'h1234, 16'h0000, 16'h0000, 16'h0000, 1, CR, 0, 0, 16'h0000, 0, 0, 16'h0000, 16'h1234, 16'h0000, 3'b001};
        vecs[12] = '{4'h7, 1, 2, 16'h7777, 16'h1111, 16'h0000, 16'h0000, 1, CR, 0, 0, 16'h0000, 0, 0, 16'h0000, 16'h7777, 16'h1111, 3'b001};
        vecs[13] = '{4'h7, 1, 2, 16'h8888, 16'hFFFF, 16'h0000, 16'h0000, 1, CR, 0, 0, 16'h0000, 0, 0, 16'h0000, 16'h8888, 16'hFFFF, 3'b001};
        vecs[14] = '{4'h3, 1, 2, 16'h7F7F, 16'h0101, 16'h0000, 16'h0000, 1, CR, 0, 0, 16'h0000, 0, 0, 16'h0000, 16'h0100, 16'h0101, 3'b001};
        vecs[15] = '{4'h3, 1, 2, 16'h8080, 16'h8080, 16'h0000, 16'h0000, 1, CR, 0, 0, 16'h0000, 0, 0, 16'h0000, 16'hFE00, 16'h8080, 3'b001};
        vecs[16] = '{4'h9, 1, 2, 16'h1001, 16'hBEEF, 16'h0004, 16'h0000, 0, CSW,0, 0, 16'h0000, 0, 0, 16'h0000, 16'h1004, 16'hBEEF, 3'b001};
        vecs[17] = '{4'h8, 1, 2, 16'hFFFF, 16'h0000, 16'h0004, 16'h0000, 7, CLW,0, 0, 16'h0000, 0, 0, 16'h0000, 16'h0002, 16'h0000, 3'b001};
        vecs[18] = '{4'hA, 1, 2, 16'hABCD, 16'h0000, 16'h0012, 16'h0000, 1, CR, 0, 0, 16'h0000, 0, 0, 16'h0000, 16'hAB12, 16'h0000, 3'b001};
        vecs[19] = '{4'hB, 1, 2, 16'hABCD, 16'h0000, 16'h0012, 16'h0000, 1, CR, 0, 0, 16'h0000, 0, 0, 16'h0000, 16'h12CD, 16'h0000, 3'b001};
        vecs[20] = '{4'hE, 1, 2, 16'h0000, 16'h0000, 16'h0000, 16'h0222, 9, CR, 0, 0, 16'h0000, 0, 0, 16'h0000, 16'h0222, 16'h0000, 3'b001};
        vecs[21] = '{4'h0, 3, 4, 16'h0AAA, 16'h0000, 16'h0000, 16'h0000, 1, CR, 3, 1, 16'h1234, 3, 1, 16'h5678, 16'h1234, 16'h0000, 3'b000};
        vecs[22] = '{4'h0, 0, 4, 16'h0042, 16'h0000, 16'h0000, 16'h0000, 1, CR, 0, 1, 16'h1111, 0, 1, 16'h2222, 16'h0042, 16'h0000, 3'b000};
        vecs[23] = '{4'h0, 1, 5, 16'h0001, 16'h0999, 16'h0000, 16'h0000, 1, CR, 6, 1, 16'h7000, 5, 1, 16'h0100, 16'h0101, 16'h0100, 3'b000};
        vecs[24] = '{4'h0, 3, 4, 16'h0AAA, 16'h0000, 16'h0000, 16'h0000, 1, CR, 3, 0, 16'h1234, 3, 1, 16'h5678, 16'h5678, 16'h0000, 3'b000};
        vecs[25] = '{4'hF, 1, 2, 16'h0000, 16'h0000, 16'h0000, 16'h0000, 0, CH, 0, 0, 16'h0000, 0, 0, 16'h0000, 16'h0000, 16'h0000, 3'b000};
        vecs[26] = '{4'hC, 1, 2, 16'h5555, 16'h0000, 16'h0000, 16'h0000, 0, CN, 2, 1, 16'hAAAA, 0, 0, 16'h0000, 16'h0000, 16'hAAAA, 3'b000};

        // Reset with a live instruction on the inputs.
        rst   = 1'b1;
        stall = 1'b0;
        flush = 1'b0;
        applyStimulus(vecs[1]);
        @(posedge clk); #1;
        checkOutput("reset", 41'h0, 3'b000);
        rst = 1'b0;

        for (int i = 0; i < 27; i++) begin
            applyStimulus(vecs[i]);
            @(posedge clk); #1;
            checkOutput($sformatf("vec%0d", i),
                        pack(vecs[i].expAlu, vecs[i].expStore, vecs[i].wr, vecs[i].ctrl),
                        vecs[i].expFlags);
        end

        // Load SUB 0-1 so flags become 001.
        applyStimulus(vecs[6]);
        @(posedge clk); #1;
        checkOutput("preFlush", pack(16'hFFFF, 16'h0001, 4'd1, CR), 3'b001);

        // Flush: bubble in, flags untouched.
        flush = 1'b1;
        applyStimulus(vecs[0]);
        @(posedge clk); #1;
        checkOutput("flush", 41'h0, 3'b001);
        flush = 1'b0;

        // Load a saturating ADD, then stall for three cycles on different inputs.
        applyStimulus(vecs[1]);
        @(posedge clk); #1;
        checkOutput("preStall", pack(16'h7FFF, 16'h0001, 4'd1, CR), 3'b010);
        stall = 1'b1;
        applyStimulus(vecs[6]);
        for (int c = 0; c < 3; c++) begin
            @(posedge clk); #1;
            checkOutput($sformatf("stall%0d", c), pack(16'h7FFF, 16'h0001, 4'd1, CR), 3'b010);
        end

        // Stall and flush together: bubble loads, flags hold.
        flush = 1'b1;
        @(posedge clk); #1;
        checkOutput("stallFlush", 41'h0, 3'b010);
        stall = 1'b0;
        flush = 1'b0;

        // Back-to-back flag-setting ops, each visible right after its edge.
        applyStimulus(vecs[2]);
        @(posedge clk); #1;
        checkOutput("b2b0", pack(16'h8000, 16'h0001, 4'd1, CR), 3'b011);
        applyStimulus(vecs[4]);
        @(posedge clk); #1;
        checkOutput("b2b1", pack(16'h0000, 16'hFFFF, 4'd1, CR), 3'b100);

        // Reset mid-operation discards the in-flight instruction.
        v = vecs[2];
        applyStimulus(v);
        rst = 1'b1;
        @(posedge clk); #1;
        checkOutput("midReset", 41'h0, 3'b000);
        rst = 1'b0;

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
